// File: rtl/line_fill_engine.sv
// Miss-refill engine: one burst read per miss, beats written into the L1 data array.
// Optional CRITICAL_WORD_FIRST_EN: wrapping burst that starts at the requested word.
module line_fill_engine #(
    parameter int NUM_SETS      = 64,
    parameter int NUM_WAYS      = 4,
    parameter int LINE_BYTES    = 16,
    parameter int ADDR_BITS     = 32,
    parameter int INDEX_BITS    = $clog2(NUM_SETS),
    parameter int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int WORD_SEL_BITS = (LINE_BYTES > 4) ? $clog2(LINE_BYTES / 4) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_BITS-1:0]     req_addr,
    input  logic [WAY_BITS-1:0]      req_way,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic                     da_we,
    output logic [INDEX_BITS-1:0]    da_index,
    output logic [WAY_BITS-1:0]      da_way,
    output logic [WORD_SEL_BITS-1:0] da_word_sel,
    output logic [31:0]              da_wdata,
    output logic                     crit_valid,
    output logic [31:0]              crit_data,
    output logic                     fill_done,
    output logic [INDEX_BITS-1:0]    fill_index,
    output logic [WAY_BITS-1:0]      fill_way,
    output logic                     busy
);

    localparam int WORDS       = LINE_BYTES / 4;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam logic [WORD_SEL_BITS-1:0] LAST = WORD_SEL_BITS'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_w;
    logic [INDEX_BITS-1:0]    index_q;
    logic [WAY_BITS-1:0]      way_q;
    logic [WORD_SEL_BITS-1:0] crit_q, crit_w;
    logic [WORD_SEL_BITS-1:0] cnt_q, start_w, word_w;

    assign crit_w = (WORDS > 1) ? req_addr[WORD_SEL_BITS+1:2] : '0;

`ifdef CRITICAL_WORD_FIRST_EN
    assign addr_w  = {req_addr[ADDR_BITS-1:2], 2'b00};
    assign start_w = crit_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];
    assign addr_w  = {req_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign start_w = '0;
`endif

    // Word index wraps naturally at the select width.
    assign word_w = start_w + cnt_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            index_q <= '0;
            way_q   <= '0;
            crit_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q  <= addr_w;
                index_q <= req_addr[OFFSET_BITS +: INDEX_BITS];
                way_q   <= req_way;
                crit_q  <= crit_w;
            end
            if (state_q == REQ && mem_req_ready)
                cnt_q <= '0;
            else if (state_q == FILL && mem_rvalid)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = REQ;
            REQ:  if (mem_req_ready) state_d = FILL;
            FILL: if (mem_rvalid && cnt_q == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_addr  = addr_q;
        da_we         = 1'b0;
        da_index      = index_q;
        da_way        = way_q;
        da_word_sel   = '0;
        da_wdata      = '0;
        crit_valid    = 1'b0;
        crit_data     = '0;
        fill_done     = 1'b0;
        fill_index    = '0;
        fill_way      = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            REQ: mem_req_valid = 1'b1;
            FILL: begin
                if (mem_rvalid) begin
                    da_we       = 1'b1;
                    da_word_sel = word_w;
                    da_wdata    = mem_rdata;
                    if (word_w == crit_q) begin
                        crit_valid = 1'b1;
                        crit_data  = mem_rdata;
                    end
                end
            end
            DONE: begin
                fill_done  = 1'b1;
                fill_index = index_q;
                fill_way   = way_q;
            end
            default: ;
        endcase
    end

endmodule
